// File: rtl/cache_ctrl.sv
// cache_ctrl: write-back/write-allocate miss sequencer for a 2-way, 32-set, 4-word-line data cache.
// Define CACHE_STAT_EN to add saturating hit/miss/write-back counters.
module cache_ctrl #(
    parameter int ADDR_BITS  = 32,
    parameter int TAG_BITS   = 23,
    parameter int LINE_WORDS = 4
`ifdef CACHE_STAT_EN
    , parameter int STAT_WIDTH = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [2:0]            req_ubhw,
    input  logic [31:0]           req_wdata,
    output logic [31:0]           resp_rdata,
    output logic                  stall,
`ifdef CACHE_STAT_EN
    output logic [STAT_WIDTH-1:0] stat_hit,
    output logic [STAT_WIDTH-1:0] stat_miss,
    output logic [STAT_WIDTH-1:0] stat_wb,
`endif
    output logic [ADDR_BITS-1:0]  c_addr,
    output logic                  c_load,
    output logic                  c_store,
    output logic                  c_edit,
    output logic                  c_invalid,
    output logic [2:0]            c_ubhw,
    output logic [31:0]           c_din,
    input  logic                  c_hit,
    input  logic [31:0]           c_dout,
    input  logic                  c_valid,
    input  logic                  c_dirty,
    input  logic [TAG_BITS-1:0]   c_tag,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);
    localparam int WB_BITS  = $clog2(LINE_WORDS);
    localparam int IDX_LO   = WB_BITS + 2;
    localparam int IDX_BITS = ADDR_BITS - TAG_BITS - IDX_LO;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, REPLAY} state_t;
    state_t state, nxt;

    logic [ADDR_BITS-1:0] a_addr;
    logic [2:0]           a_ubhw;
    logic [31:0]          a_wdata;
    logic                 a_st;
    logic [TAG_BITS-1:0]  vtag;
    logic [WB_BITS-1:0]   beat;
    logic                 wb_ph;
    logic                 replay;

    logic                 req, rpl, issue, iss_st, wb_mem, fill, hit, ack, last;
    logic [IDX_BITS-1:0]  idx;
    logic [ADDR_BITS-1:0] line_addr;

    assign req       = req_rd | req_wr;
    assign rpl       = state == REPLAY;
    assign issue     = rst && ((state == IDLE && req) || rpl);
    assign iss_st    = rpl ? a_st : req_wr;
    assign wb_mem    = state == WB && wb_ph;
    assign fill      = state == FILL;
    assign hit       = state == LOOKUP && c_hit;
    assign ack       = (wb_mem || fill) && mem_ack;
    assign last      = beat == WB_BITS'(LINE_WORDS - 1);
    assign idx       = a_addr[IDX_LO+IDX_BITS-1:IDX_LO];
    assign line_addr = {a_addr[ADDR_BITS-1:IDX_LO], beat, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = req ? LOOKUP : IDLE;
            LOOKUP:  nxt = c_hit ? IDLE : (!replay && c_valid && c_dirty) ? WB : FILL;
            WB:      nxt = (ack && last) ? FILL : WB;
            FILL:    nxt = (ack && last) ? REPLAY : FILL;
            REPLAY:  nxt = LOOKUP;
            default: nxt = IDLE;
        endcase
    end

    // Each write-back beat spends one cycle addressing the victim word before the memory phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_addr  <= '0;
            a_ubhw  <= '0;
            a_wdata <= '0;
            a_st    <= 1'b0;
            vtag    <= '0;
            beat    <= '0;
            wb_ph   <= 1'b0;
            replay  <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                a_addr  <= req_addr;
                a_ubhw  <= req_ubhw;
                a_wdata <= req_wdata;
                a_st    <= req_wr;
            end
            if (state == LOOKUP && !c_hit) vtag <= c_tag;
            if (ack) beat <= last ? '0 : beat + 1'b1;
            wb_ph  <= state == WB && !(wb_ph && mem_ack);
            replay <= rpl;
        end
    end

    always_comb begin
        stall      = state == IDLE ? req : !hit;
        resp_rdata = hit ? c_dout : '0;
        c_load     = issue && !iss_st;
        c_edit     = issue && iss_st;
        c_store    = fill && mem_ack;
        c_invalid  = 1'b0;
        c_ubhw     = issue ? (rpl ? a_ubhw : req_ubhw) : '0;
        c_addr     = issue ? (rpl ? a_addr : req_addr) :
                     state == WB ? {{TAG_BITS{1'b0}}, idx, beat, 2'b00} :
                     c_store ? line_addr : '0;
        c_din      = c_edit ? (rpl ? a_wdata : req_wdata) : c_store ? mem_rdata : '0;
        mem_cs     = wb_mem || fill;
        mem_we     = wb_mem;
        mem_addr   = wb_mem ? {vtag, idx, beat, 2'b00} : fill ? line_addr : '0;
        mem_wdata  = wb_mem ? c_dout : '0;
    end

`ifdef CACHE_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hit  <= '0;
            stat_miss <= '0;
            stat_wb   <= '0;
        end else begin
            if (hit && !replay && ~&stat_hit) stat_hit <= stat_hit + 1'b1;
            if (state == LOOKUP && !c_hit && ~&stat_miss) stat_miss <= stat_miss + 1'b1;
            if (state == LOOKUP && nxt == WB && ~&stat_wb) stat_wb <= stat_wb + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench with a behavioural 2-way cache array and a 2-cycle-ack word memory.
module tb_cache_ctrl;
    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_rd = 1'b0, req_wr = 1'b0;
    logic [2:0]  req_ubhw = '0;
    logic [31:0] resp_rdata, c_addr, c_din, mem_addr, mem_wdata, mem_rdata;
    logic        stall, c_load, c_store, c_edit, c_invalid, mem_cs, mem_we, mem_ack;
    logic [2:0]  c_ubhw;
    logic        c_hit = 1'b0, c_valid = 1'b0, c_dirty = 1'b0;
    logic [31:0] c_dout = '0;
    logic [22:0] c_tag = '0;
    logic        ack_r = 1'b0, stray = 1'b0;
    int          nchk = 0, nerr = 0;
`ifdef CACHE_STAT_EN
    logic [31:0] stat_hit, stat_miss, stat_wb;
`endif

    cache_ctrl dut (
        .clk(clk), .rst(rst), .req_addr(req_addr), .req_rd(req_rd), .req_wr(req_wr),
        .req_ubhw(req_ubhw), .req_wdata(req_wdata), .resp_rdata(resp_rdata), .stall(stall),
`ifdef CACHE_STAT_EN
        .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_wb(stat_wb),
`endif
        .c_addr(c_addr), .c_load(c_load), .c_store(c_store), .c_edit(c_edit),
        .c_invalid(c_invalid), .c_ubhw(c_ubhw), .c_din(c_din), .c_hit(c_hit), .c_dout(c_dout),
        .c_valid(c_valid), .c_dirty(c_dirty), .c_tag(c_tag), .mem_addr(mem_addr),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Word memory: ack arrives in the second cycle of each request
    logic [31:0] mem [1024];
    logic [31:0] lg_addr [64], lg_data [64];
    logic        lg_we [64];
    int          nlog = 0;
    assign mem_rdata = mem[mem_addr[11:2]];
    assign mem_ack   = ack_r | stray;
    always @(posedge clk) begin
        ack_r <= mem_cs && !ack_r;
        if (mem_cs && mem_ack) begin
            if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            if (nlog < 64) begin
                lg_addr[nlog] = mem_addr;
                lg_data[nlog] = mem_we ? mem_wdata : mem_rdata;
                lg_we[nlog]   = mem_we;
            end
            nlog = nlog + 1;
        end
    end

    // Cache array model: registered hit/dout; on a miss it reports the victim way
    logic [31:0] cd [2][32][4];
    logic [22:0] ct [2][32];
    logic        cv [2][32], cdy [2][32], lru [32];

    function automatic logic [31:0] ld_fmt(input logic [31:0] w, input logic [2:0] ub, input logic [1:0] off);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (ub)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd4:    return {24'd0, s[7:0]};
            3'd5:    return {16'd0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] d, input logic [2:0] ub, input logic [1:0] off);
        logic [31:0] m;
        m = ub[1] ? 32'hFFFF_FFFF : ub[0] ? 32'h0000_FFFF : 32'h0000_00FF;
        m = m << {off, 3'b000};
        return (w & ~m) | ((d << {off, 3'b000}) & m);
    endfunction

    always @(posedge clk) begin
        automatic logic [4:0]  s = c_addr[8:4];
        automatic logic [1:0]  w = c_addr[3:2];
        automatic logic [22:0] t = c_addr[31:9];
        automatic logic h0  = cv[0][s] && ct[0][s] == t;
        automatic logic h1  = cv[1][s] && ct[1][s] == t;
        automatic logic vic = !cv[0][s] ? 1'b0 : !cv[1][s] ? 1'b1 : lru[s];
        automatic logic sw  = (h0 || h1) ? h1 : vic;
        c_hit   <= (c_load || c_edit) && (h0 || h1);
        c_valid <= cv[vic][s];
        c_dirty <= cdy[vic][s];
        c_tag   <= ct[vic][s];
        c_dout  <= (c_load && (h0 || h1)) ? ld_fmt(cd[h1][s][w], c_ubhw, c_addr[1:0]) : cd[vic][s][w];
        if (c_edit && (h0 || h1)) begin
            cd[h1][s][w] = st_merge(cd[h1][s][w], c_din, c_ubhw, c_addr[1:0]);
            cdy[h1][s]   = 1'b1;
        end
        if ((c_load || c_edit) && (h0 || h1)) lru[s] = !h1;
        if (c_store) begin
            cd[sw][s][w] = c_din;
            ct[sw][s]    = t;
            cv[sw][s]    = 1'b1;
            cdy[sw][s]   = 1'b0;
            lru[s]       = !sw;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    logic        i_load, i_edit;
    logic [31:0] i_din;

    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] ub,
                          input logic [31:0] wd, output logic [31:0] rdata, output int cyc);
        @(negedge clk);
        req_rd = rd; req_wr = wr; req_addr = a; req_ubhw = ub; req_wdata = wd;
        #1;
        i_load = c_load; i_edit = c_edit; i_din = c_din;
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        if (cyc >= 100) chk("timeout", cyc, 0);
        rdata = resp_rdata;
        @(posedge clk);
        #1;
        req_rd = 1'b0; req_wr = 1'b0;
    endtask

    task automatic chk_reads(input string tag, input int first, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_addr"}, lg_addr[first+i], base + 32'(4 * i));
            chk({tag, "_we"}, 32'(lg_we[first+i]), 0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] wbx [4];
        int cyc, n0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) begin
            mem[32'h40+i]  = 32'hA0 + 32'(i);
            mem[32'hC0+i]  = 32'hB0 + 32'(i);
            mem[32'h140+i] = 32'hC0 + 32'(i);
            mem[32'h180+i] = 32'hD0 + 32'(i);
            mem[32'h80+i]  = 32'hE0 + 32'(i);
        end
        for (int i = 0; i < 32; i++) begin
            cv[0][i] = 1'b0; cv[1][i] = 1'b0; cdy[0][i] = 1'b0; cdy[1][i] = 1'b0; lru[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_cs", 32'(mem_cs), 0);
        req_rd = 1'b1; req_addr = 32'h100; req_ubhw = 3'd2;
        #1;
        chk("rst_stall_req", 32'(stall), 1);
        chk("rst_load", 32'(c_load), 0);
        chk("rst_caddr", c_addr, 0);
        req_rd = 1'b0;
        @(negedge clk) rst = 1'b1;

        n0 = nlog;
        access(1, 0, 32'h100, 3'd2, 0, rd, cyc);
        chk("cold_rdata", rd, 32'hA0);
        chk("cold_stall", cyc, 11);
        chk("cold_beats", nlog - n0, 4);
        chk_reads("cold", n0, 32'h100);

        n0 = nlog;
        access(1, 0, 32'h104, 3'd2, 0, rd, cyc);
        chk("hit_rdata", rd, 32'hA1);
        chk("hit_stall", cyc, 1);
        chk("hit_beats", nlog - n0, 0);

        n0 = nlog;
        access(0, 1, 32'h101, 3'd0, 32'h55, rd, cyc);
        chk("sb_stall", cyc, 1);
        access(1, 0, 32'h101, 3'd4, 0, rd, cyc);
        chk("lbu_rdata", rd, 32'h55);
        chk("lbu_stall", cyc, 1);
        chk("sb_beats", nlog - n0, 0);

        n0 = nlog;
        access(1, 0, 32'h300, 3'd2, 0, rd, cyc);
        chk("b_rdata", rd, 32'hB0);
        chk("b_beats", nlog - n0, 4);
        chk_reads("b", n0, 32'h300);

        n0 = nlog;
        wbx[0] = 32'h55A0; wbx[1] = 32'hA1; wbx[2] = 32'hA2; wbx[3] = 32'hA3;
        access(1, 0, 32'h500, 3'd2, 0, rd, cyc);
        chk("wb_rdata", rd, 32'hC0);
        chk("wb_stall", cyc, 23);
        chk("wb_beats", nlog - n0, 8);
        for (int i = 0; i < 4; i++) begin
            chk("wb_addr", lg_addr[n0+i], 32'h100 + 32'(4 * i));
            chk("wb_we", 32'(lg_we[n0+i]), 1);
            chk("wb_data", lg_data[n0+i], wbx[i]);
        end
        chk_reads("wbfill", n0 + 4, 32'h500);

        n0 = nlog;
        access(1, 1, 32'h104, 3'd2, 32'hDEAD_BEEF, rd, cyc);
        chk("rw_edit", 32'(i_edit), 1);
        chk("rw_load", 32'(i_load), 0);
        chk("rw_din", i_din, 32'hDEAD_BEEF);
        chk("rw_stall", cyc, 11);
        chk_reads("rw", n0, 32'h100);
        access(1, 0, 32'h104, 3'd2, 0, rd, cyc);
        chk("rw_rdata", rd, 32'hDEAD_BEEF);

        @(negedge clk) stray = 1'b1;
        @(negedge clk) stray = 1'b0;
        #1;
        chk("stray_cs", 32'(mem_cs), 0);
        chk("stray_stall", 32'(stall), 0);
        n0 = nlog;
        access(1, 0, 32'h108, 3'd2, 0, rd, cyc);
        chk("stray_rdata", rd, 32'hA2);
        chk("stray_stall2", cyc, 1);
        chk("stray_beats", nlog - n0, 0);
`ifdef CACHE_STAT_EN
        chk("stat_hit", stat_hit, 5);
        chk("stat_miss", stat_miss, 4);
        chk("stat_wb", stat_wb, 1);
`endif

        @(negedge clk);
        req_rd = 1'b1; req_addr = 32'h600; req_ubhw = 3'd2;
        n0 = nlog; cyc = 0;
        while (nlog == n0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_beat1", nlog - n0, 1);
        rst = 1'b0;
        #1;
        chk("abort_stall", 32'(stall), 1);
        chk("abort_cs", 32'(mem_cs), 0);
        chk("abort_store", 32'(c_store), 0);
        req_rd = 1'b0;
        #1;
        chk("abort_stall0", 32'(stall), 0);
        @(negedge clk) rst = 1'b1;
        n0 = nlog;
        access(1, 0, 32'h200, 3'd2, 0, rd, cyc);
        chk("after_rdata", rd, 32'hE0);
        chk("after_stall", cyc, 11);
        chk_reads("after", n0, 32'h200);
`ifdef CACHE_STAT_EN
        chk("stat_hit_rst", stat_hit, 0);
        chk("stat_miss_rst", stat_miss, 1);
`endif
        chk("invalid", 32'(c_invalid), 0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
